// File: rtl/ddr4_v2_2_20_axi_ctrl_lite_regfile.sv
// ddr4_v2_2_20_axi_ctrl_lite_regfile: parameterised AXI4-Lite register file (RO/RW/W1C slots) for the DDR4 control path
// Ports: aclk/areset (async, active-high); s_axi_aw*/w*/b* write channels; s_axi_ar*/r* read channels;
//        reg_status_in live RO values; reg_set_in W1C hardware sets; reg_q RW/W1C contents; reg_wr_pulse per-slot write strobe.
module ddr4_v2_2_20_axi_ctrl_lite_regfile #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REG = 8,
  parameter int C_NUM_REG_WIDTH = 3,
  parameter logic [C_NUM_REG*C_ADDR_WIDTH-1:0] C_REG_ADDR_ARRAY = {C_NUM_REG{32'hFFFF_FFFF}},
  parameter logic [2*C_NUM_REG-1:0] C_REG_MODE_ARRAY = '0,
  parameter logic [C_NUM_REG*C_DATA_WIDTH-1:0] C_REG_INIT_ARRAY = '0,
  parameter int C_DECERR_EN = 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_ADDR_WIDTH-1:0]           s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]           s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]         s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]           s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  input  logic [C_NUM_REG*C_DATA_WIDTH-1:0] reg_status_in,
  input  logic [C_NUM_REG*C_DATA_WIDTH-1:0] reg_set_in,
  output logic [C_NUM_REG*C_DATA_WIDTH-1:0] reg_q,
  output logic [C_NUM_REG-1:0]              reg_wr_pulse
);
  localparam int SB = C_DATA_WIDTH/8;
  localparam int LSB = (C_DATA_WIDTH == 64) ? 3 : 2;
  localparam int WW = C_ADDR_WIDTH - LSB;
  localparam logic [1:0] M_NONE = 2'b00, M_RO = 2'b01, M_RW = 2'b10, M_W1C = 2'b11;
  localparam logic [1:0] W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_RESP = 1'b1;
  localparam logic [1:0] UNMAP_RESP = (C_DECERR_EN != 0) ? 2'b11 : 2'b00;

  function automatic logic [1:0] mode_of(input logic [C_NUM_REG_WIDTH-1:0] idx);
    return C_REG_MODE_ARRAY[2*idx +: 2];
  endfunction

  // Slot 0 is the miss index, so the search starts at 1.
  function automatic logic [C_NUM_REG_WIDTH-1:0] decode(input logic [C_ADDR_WIDTH-1:0] a);
    decode = '0;
    for (int i = 1; i < C_NUM_REG; i++)
      if (C_REG_MODE_ARRAY[2*i +: 2] != M_NONE && a[C_ADDR_WIDTH-1:LSB] == C_REG_ADDR_ARRAY[i*C_ADDR_WIDTH+LSB +: WW])
        decode = C_NUM_REG_WIDTH'(i);
  endfunction

  // Only RW/W1C slots hold state; everything else resets (and stays) at zero.
  function automatic logic [C_NUM_REG*C_DATA_WIDTH-1:0] init_val();
    init_val = C_REG_INIT_ARRAY;
    for (int i = 0; i < C_NUM_REG; i++)
      if (!C_REG_MODE_ARRAY[2*i+1]) init_val[i*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
  endfunction
  localparam logic [C_NUM_REG*C_DATA_WIDTH-1:0] INIT = init_val();

  logic [1:0] w_state_q, w_state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, awready_q, wready_q;
  logic [C_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_DATA_WIDTH-1:0] wdata_q, wmask;
  logic [SB-1:0] wstrb_q;
  logic [1:0] bresp_q, bresp_d;
  logic [C_NUM_REG-1:0] wr_pulse_q, wr_pulse_d;
  logic [C_NUM_REG*C_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [C_NUM_REG_WIDTH-1:0] wr_idx, rd_idx;
  logic [1:0] wr_mode, rd_mode;
  logic aw_hs, w_hs, wr_en;
  logic [0:0] r_state_q, r_state_d;
  logic arready_q, ar_hs;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs = s_axi_wvalid & wready_q;
  assign wr_en = w_state_q == W_EXEC;
  assign wr_idx = decode(aw_addr_q);
  assign wr_mode = mode_of(wr_idx);
  assign bresp_d = wr_mode == M_RO ? 2'b10 : wr_mode == M_NONE ? UNMAP_RESP : 2'b00;
  assign wr_pulse_d = (wr_en && wr_mode[1]) ? {{(C_NUM_REG-1){1'b0}}, 1'b1} << wr_idx : '0;

  always_comb begin
    aw_held_d = aw_held_q | aw_hs;
    w_held_d = w_held_q | w_hs;
    w_state_d = w_state_q;
    if (w_state_q == W_IDLE && aw_held_d && w_held_d) w_state_d = W_EXEC;
    if (w_state_q == W_EXEC) w_state_d = W_RESP;
    if (w_state_q == W_RESP && s_axi_bready) begin
      w_state_d = W_IDLE;
      aw_held_d = 1'b0;
      w_held_d = 1'b0;
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < SB; b++) wmask[8*b +: 8] = {8{wstrb_q[b]}};
  end

  // Hardware set is OR-ed after the clear so a coincident set wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < C_NUM_REG; i++)
      if (C_REG_MODE_ARRAY[2*i +: 2] == M_RW)
        regs_d[i*C_DATA_WIDTH +: C_DATA_WIDTH] = (wr_en && int'(wr_idx) == i) ?
          (regs_q[i*C_DATA_WIDTH +: C_DATA_WIDTH] & ~wmask) | (wdata_q & wmask) : regs_q[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      else if (C_REG_MODE_ARRAY[2*i +: 2] == M_W1C)
        regs_d[i*C_DATA_WIDTH +: C_DATA_WIDTH] = (regs_q[i*C_DATA_WIDTH +: C_DATA_WIDTH] &
          ~((wr_en && int'(wr_idx) == i) ? wdata_q & wmask : '0)) | reg_set_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      else
        regs_d[i*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
  end

  // Readies are registered from next state so they only rise on the first edge after reset.
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      aw_addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= 2'b00;
      wr_pulse_q <= '0;
      regs_q <= INIT;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      awready_q <= w_state_d == W_IDLE && !aw_held_d;
      wready_q <= w_state_d == W_IDLE && !w_held_d;
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_en) bresp_q <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q <= regs_d;
    end

  assign ar_hs = s_axi_arvalid & arready_q;
  assign rd_idx = decode(s_axi_araddr);
  assign rd_mode = mode_of(rd_idx);
  assign rdata_d = rd_mode == M_RO ? reg_status_in[rd_idx*C_DATA_WIDTH +: C_DATA_WIDTH] :
                   rd_mode[1] ? regs_q[rd_idx*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
  assign rresp_d = rd_mode == M_NONE ? UNMAP_RESP : 2'b00;
  assign r_state_d = (r_state_q == R_IDLE && ar_hs) ? R_RESP :
                     (r_state_q == R_RESP && s_axi_rready) ? R_IDLE : r_state_q;

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= r_state_d == R_IDLE;
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end

  assign s_axi_awready = awready_q;
  assign s_axi_wready = wready_q;
  assign s_axi_bvalid = w_state_q == W_RESP;
  assign s_axi_bresp = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid = r_state_q == R_RESP;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign reg_q = regs_q;
  assign reg_wr_pulse = wr_pulse_q;
endmodule
